// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: special instruction words, fetch state encoding
// and the PC increment.
package mips_pkg;

    localparam int unsigned WORD_NB = 32;

    localparam logic [WORD_NB-1:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [WORD_NB-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [WORD_NB-1:0] PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        FETCH_LOAD = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: synchronous debug write port, asynchronous fetch read port.
// Contents are deliberately not reset so a loaded program survives a pipeline reset.
module instruction_memory #(
    parameter int unsigned NB        = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_NB   = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_NB-1:0] i_waddr,
    input  logic [NB-1:0]      i_wdata,
    input  logic [ADDR_NB-1:0] i_raddr,
    output logic [NB-1:0]      o_rdata_c
);

    logic [NB-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, LOAD/RUN/HALT control, debug-loaded instruction memory and IF/ID register.
// Optional feature macro: IF_FETCH_COUNT_EN adds o_fetch_count (non-flushed advance counter).
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned NB        = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_NB   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_pc_src,
    input  logic [NB-1:0]      i_branch_target,
    input  logic               i_load_en,
    input  logic [ADDR_NB-1:0] i_load_addr,
    input  logic [NB-1:0]      i_load_data,
    output logic [NB-1:0]      o_instruction,
    output logic [NB-1:0]      o_pc_plus4,
    output logic [NB-1:0]      o_pc,
`ifdef IF_FETCH_COUNT_EN
    output logic [NB-1:0]      o_fetch_count,
`endif
    output logic               o_halt
);

    fetch_state_e state_q, state_d;
    logic [NB-1:0] pc_q, pc_d;
    logic [NB-1:0] instr_q, instr_d;
    logic [NB-1:0] pc_plus4_q, pc_plus4_d;
    logic          halt_q, halt_d;

    logic [NB-1:0] pc_incr;
    logic [NB-1:0] fetch_word;
    logic          mem_we;
    logic          update;

`ifdef IF_FETCH_COUNT_EN
    logic [NB-1:0] fetch_count_q, fetch_count_d;
`endif

    instruction_memory #(
        .NB       (NB),
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_NB  (ADDR_NB)
    ) u_imem (
        .i_clk    (i_clk),
        .i_we     (mem_we),
        .i_waddr  (i_load_addr),
        .i_wdata  (i_load_data),
        .i_raddr  (pc_q[ADDR_NB+1:2]),
        .o_rdata_c(fetch_word)
    );

    // Next-state and datapath: flush forces an update even under a stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        halt_d     = halt_q;
        mem_we     = 1'b0;
        update     = 1'b0;
        pc_incr    = pc_q + NB'(PC_INCR);
`ifdef IF_FETCH_COUNT_EN
        fetch_count_d = fetch_count_q;
`endif

        case (state_q)
            FETCH_LOAD: begin
                mem_we = i_load_en;
                if (i_start) begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                update = i_step & (~i_stall | i_flush);
                if (update) begin
                    pc_plus4_d = pc_incr;
                    pc_d       = i_pc_src ? i_branch_target : pc_incr;
                    if (i_flush) begin
                        instr_d = NB'(NOP_WORD);
                    end else begin
                        instr_d = fetch_word;
`ifdef IF_FETCH_COUNT_EN
                        fetch_count_d = fetch_count_q + NB'(1);
`endif
                        // HALT pins the PC at its own address.
                        if (fetch_word == NB'(HALT_WORD)) begin
                            state_d = FETCH_HALT;
                            halt_d  = 1'b1;
                            pc_d    = pc_q;
                        end
                    end
                end
            end
            FETCH_HALT: begin
                state_d = FETCH_HALT;
            end
            default: begin
                state_d = FETCH_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= FETCH_LOAD;
            pc_q       <= '0;
            instr_q    <= NB'(NOP_WORD);
            pc_plus4_q <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            halt_q     <= halt_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign o_fetch_count = fetch_count_q;
`endif

    assign o_instruction = instr_q;
    assign o_pc_plus4    = pc_plus4_q;
    assign o_pc          = pc_q;
    assign o_halt        = halt_q;

endmodule
